fifo_sp_arbiter: RTL and testbench

//  Controller for a FIFO built on a single-port RAM, where only one access can happen per cycle.

---
 rtl/fifo_sp_arbiter.sv | 116 +++++++++++
 tb/tb_fifo_sp_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sp_arbiter.sv
// FIFO controller for a single-port RAM: arbitrates push/pop requests so that
// at most one RAM access is issued per cycle, and owns the pointers, the
// occupancy count and the full/empty flags. Data muxing lives outside.
module fifo_sp_arbiter #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          arst,
  input  logic          wr_req,
  input  logic          rd_req,
  output logic          wr_ack,
  output logic          rd_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic          rd_valid,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  // The state names the RAM access being driven this cycle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_e;

  // Remembers which side won the last grant, for tie alternation.
  typedef enum logic {
    GNT_WRITE = 1'b0,
    GNT_READ  = 1'b1
  } grant_e;

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  state_e        state_q, state_d;
  grant_e        last_grant_q, last_grant_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [AW:0]   count_q, count_d;
  logic          rd_valid_q, rd_valid_d;

  logic wr_legal;
  logic rd_legal;
  logic wr_gnt;
  logic rd_gnt;

  // Flags come straight from the registered count, so a request only sees
  // occupancy as of the start of the cycle.
  assign full  = (count_q == DEPTH);
  assign empty = (count_q == '0);

  // Pick at most one legal request; on a tie the side that lost last time wins.
  always_comb begin
    wr_legal = wr_req & ~full;
    rd_legal = rd_req & ~empty;
    wr_gnt   = wr_legal & (~rd_legal | (last_grant_q == GNT_READ));
    rd_gnt   = rd_legal & (~wr_legal | (last_grant_q == GNT_WRITE));
  end

  // Next state, pointer, count and RAM address derived from this cycle's grant.
  always_comb begin
    state_d      = IDLE;
    last_grant_d = last_grant_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    mem_addr_d   = mem_addr_q;
    count_d      = count_q;
    rd_valid_d   = (state_q == READ);
    if (wr_gnt) begin
      state_d      = WRITE;
      last_grant_d = GNT_WRITE;
      mem_addr_d   = wr_ptr_q;
      wr_ptr_d     = wr_ptr_q + AW'(1);
      count_d      = count_q + (AW+1)'(1);
    end else if (rd_gnt) begin
      state_d      = READ;
      last_grant_d = GNT_READ;
      mem_addr_d   = rd_ptr_q;
      rd_ptr_d     = rd_ptr_q + AW'(1);
      count_d      = count_q - (AW+1)'(1);
    end
  end

  // State register; reset also cancels any access or read return in flight.
  always_ff @(posedge clk) begin
    if (arst) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_READ;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      mem_addr_q   <= '0;
      count_q      <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mem_addr_q   <= mem_addr_d;
      count_q      <= count_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  assign wr_ack   = wr_gnt;
  assign rd_ack   = rd_gnt;
  assign mem_en   = (state_q != IDLE);
  assign mem_we   = (state_q == WRITE);
  assign mem_addr = mem_addr_q;
  assign rd_valid = rd_valid_q;
  assign count    = count_q;

endmodule

// File: tb/tb_fifo_sp_arbiter.sv
// Directed bench for fifo_sp_arbiter with a 4-entry FIFO (AW=2).
module tb_fifo_sp_arbiter;

  localparam int AW = 2;

  logic          clk;
  logic          arst;
  logic          wr_req;
  logic          rd_req;
  logic          wr_ack;
  logic          rd_ack;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic          rd_valid;
  logic [AW:0]   count;
  logic          full;
  logic          empty;

  int checks;
  int errors;

  fifo_sp_arbiter #(.AW(AW)) dut (
    .clk      (clk),
    .arst     (arst),
    .wr_req   (wr_req),
    .rd_req   (rd_req),
    .wr_ack   (wr_ack),
    .rd_ack   (rd_ack),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .rd_valid (rd_valid),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Holds reset for two edges, then releases it on a falling edge.
  task automatic do_reset();
    @(negedge clk);
    arst   = 1'b1;
    wr_req = 1'b0;
    rd_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    arst = 1'b0;
  endtask

  // Drives one request cycle starting at the falling edge; acks settle #1 later.
  task automatic drive(input logic w, input logic r);
    @(negedge clk);
    wr_req = w;
    rd_req = r;
    #1;
  endtask

  // Advances past the next rising edge so registered outputs can be sampled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Post-reset outputs: {mem_en,mem_we,mem_addr,rd_valid,full,empty,count}.
  task automatic test_reset();
    logic [AW+8:0] obs;
    do_reset();
    obs = {mem_en, mem_we, mem_addr, rd_valid, full, empty, count};
    checks++;
    if (obs !== {1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 3'd0}) begin
      errors++;
      $display("[TB] FAIL reset_outputs got %b want %b", obs, {1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 3'd0});
    end
  endtask

  // Four pushes fill the FIFO at addresses 0..3; a fifth is refused.
  task automatic test_fill();
    logic [5:0] obs;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0);
      checks++;
      if ({wr_ack, rd_ack} !== 2'b10) begin
        errors++;
        $display("[TB] FAIL fill_ack%0d got %b want 10", k, {wr_ack, rd_ack});
      end
      step();
      obs = {mem_en, mem_we, mem_addr, 2'b00};
      checks++;
      if (obs !== {1'b1, 1'b1, k[1:0], 2'b00} || count !== 3'(k + 1)) begin
        errors++;
        $display("[TB] FAIL fill_access%0d got en/we/addr %b count %0d want %b count %0d",
                 k, obs[5:2], count, {1'b1, 1'b1, k[1:0]}, k + 1);
      end
    end
    checks++;
    if ({full, empty} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL fill_full got full/empty %b want 10", {full, empty});
    end
    drive(1'b1, 1'b0);
    checks++;
    if (wr_ack !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fill_5th_ack got %b want 0", wr_ack);
    end
    step();
    checks++;
    if (mem_en !== 1'b0 || count !== 3'd4) begin
      errors++;
      $display("[TB] FAIL fill_5th_access got mem_en %b count %0d want 0 count 4", mem_en, count);
    end
  endtask

  // Pops from an empty FIFO are refused; a tie on empty goes to the write.
  task automatic test_empty();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b1);
      checks++;
      if (rd_ack !== 1'b0) begin
        errors++;
        $display("[TB] FAIL empty_rd_ack%0d got %b want 0", k, rd_ack);
      end
      step();
      checks++;
      if ({mem_en, rd_valid, empty} !== 3'b001 || count !== 3'd0) begin
        errors++;
        $display("[TB] FAIL empty_state%0d got en/valid/empty %b count %0d want 001 count 0",
                 k, {mem_en, rd_valid, empty}, count);
      end
    end
    drive(1'b1, 1'b1);
    checks++;
    if ({wr_ack, rd_ack} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL empty_tie got wr/rd ack %b want 10", {wr_ack, rd_ack});
    end
    step();
  endtask

  // Ties alternate W,R,W,R starting from a state whose last grant was a read.
  task automatic test_alternation();
    logic       exp_w [4];
    logic [2:0] exp_cnt [4];
    logic [1:0] exp_addr [4];
    exp_w    = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp_cnt  = '{3'd3, 3'd2, 3'd3, 3'd2};
    exp_addr = '{2'd3, 2'd1, 2'd0, 2'd2};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0);
      step();
    end
    drive(1'b0, 1'b1);
    step();
    checks++;
    if (count !== 3'd2) begin
      errors++;
      $display("[TB] FAIL alt_setup_count got %0d want 2", count);
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1);
      checks++;
      if ({wr_ack, rd_ack} !== {exp_w[k], ~exp_w[k]}) begin
        errors++;
        $display("[TB] FAIL alt_grant%0d got wr/rd ack %b want %b", k, {wr_ack, rd_ack}, {exp_w[k], ~exp_w[k]});
      end
      step();
      checks++;
      if (count !== exp_cnt[k] || mem_we !== exp_w[k] || mem_addr !== exp_addr[k]) begin
        errors++;
        $display("[TB] FAIL alt_access%0d got count %0d we %b addr %0d want count %0d we %b addr %0d",
                 k, count, mem_we, mem_addr, exp_cnt[k], exp_w[k], exp_addr[k]);
      end
    end
  endtask

  // A single pop: RAM read in N+1, rd_valid only in N+2.
  task automatic test_single_pop();
    do_reset();
    drive(1'b1, 1'b0);
    step();
    drive(1'b0, 1'b0);
    step();
    drive(1'b0, 1'b1);
    checks++;
    if (rd_ack !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pop_ack got %b want 1", rd_ack);
    end
    step();
    checks++;
    if ({mem_en, mem_we, mem_addr, rd_valid} !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL pop_n1 got en/we/addr/valid %b want 10000", {mem_en, mem_we, mem_addr, rd_valid});
    end
    drive(1'b0, 1'b0);
    step();
    checks++;
    if ({mem_en, rd_valid} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL pop_n2 got en/valid %b want 01", {mem_en, rd_valid});
    end
    step();
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pop_n3 got rd_valid %b want 0", rd_valid);
    end
  endtask

  // Six push/pop pairs wrap both pointers through 3 -> 0.
  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0);
      step();
      checks++;
      if ({mem_we, mem_addr} !== {1'b1, 2'(i)} || {full, empty} !== 2'b00 || count !== 3'd1) begin
        errors++;
        $display("[TB] FAIL wrap_push%0d got we/addr %b full/empty %b count %0d want %b 00 count 1",
                 i, {mem_we, mem_addr}, {full, empty}, count, {1'b1, 2'(i)});
      end
      drive(1'b0, 1'b1);
      step();
      checks++;
      if ({mem_we, mem_addr} !== {1'b0, 2'(i)} || {full, empty} !== 2'b01 || count !== 3'd0) begin
        errors++;
        $display("[TB] FAIL wrap_pop%0d got we/addr %b full/empty %b count %0d want %b 01 count 0",
                 i, {mem_we, mem_addr}, {full, empty}, count, {1'b0, 2'(i)});
      end
    end
  endtask

  // Full with both requests: read wins; then back-to-back pops stream rd_valid.
  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0);
      step();
    end
    for (int k = 0; k < 4; k++) begin
      drive(k == 0, 1'b1);
      checks++;
      if ({wr_ack, rd_ack} !== 2'b01) begin
        errors++;
        $display("[TB] FAIL b2b_ack%0d got wr/rd ack %b want 01", k, {wr_ack, rd_ack});
      end
      step();
      checks++;
      if ({mem_en, mem_we, mem_addr} !== {2'b10, 2'(k)} || rd_valid !== (k >= 1) || full !== 1'b0) begin
        errors++;
        $display("[TB] FAIL b2b_pop%0d got en/we/addr %b valid %b full %b want %b valid %b full 0",
                 k, {mem_en, mem_we, mem_addr}, rd_valid, full, {2'b10, 2'(k)}, (k >= 1));
      end
    end
    drive(1'b0, 1'b0);
    step();
    checks++;
    if ({mem_en, rd_valid, empty} !== 3'b011) begin
      errors++;
      $display("[TB] FAIL b2b_tail got en/valid/empty %b want 011", {mem_en, rd_valid, empty});
    end
    step();
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_done got rd_valid %b want 0", rd_valid);
    end
  endtask

  // Reset during an in-flight read cancels the access and its rd_valid.
  task automatic test_reset_inflight();
    do_reset();
    drive(1'b1, 1'b0);
    step();
    drive(1'b1, 1'b0);
    step();
    drive(1'b0, 1'b1);
    step();
    checks++;
    if ({mem_en, mem_we} !== 2'b10 || count !== 3'd1) begin
      errors++;
      $display("[TB] FAIL rst_setup got en/we %b count %0d want 10 count 1", {mem_en, mem_we}, count);
    end
    @(negedge clk);
    arst   = 1'b1;
    rd_req = 1'b0;
    step();
    checks++;
    if ({mem_en, rd_valid, empty} !== 3'b001 || count !== 3'd0) begin
      errors++;
      $display("[TB] FAIL rst_inflight got en/valid/empty %b count %0d want 001 count 0",
               {mem_en, rd_valid, empty}, count);
    end
    @(negedge clk);
    arst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    arst   = 1'b1;
    wr_req = 1'b0;
    rd_req = 1'b0;
    test_reset();
    test_fill();
    test_empty();
    test_alternation();
    test_single_pop();
    test_wrap();
    test_back_to_back();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
